// File: rtl/hdlc_pkg.sv
// hdlc_pkg
//   Shared types and constants for the HDLC receive path.
//   - state_e     : deframer FSM states
//   - WIN_W       : width of the accepted-bit window
//   - RSV_BITS    : bits held back as a possible closing flag
//   - CNT_W       : width of the window bit count
//   - CRC_POLY    : reflected CRC-16/X.25 polynomial
//   - CRC_INIT    : CRC preset value
//   - CRC_RESIDUE : CRC value left after a frame with a good FCS
package hdlc_pkg;

  typedef enum logic [1:0] {
    HUNT = 2'd0,
    OPEN = 2'd1,
    DATA = 2'd2
  } state_e;

  localparam int WIN_W    = 15;
  localparam int RSV_BITS = 7;
  localparam int CNT_W    = 4;

  localparam logic [15:0] CRC_POLY    = 16'h8408;
  localparam logic [15:0] CRC_INIT    = 16'hFFFF;
  localparam logic [15:0] CRC_RESIDUE = 16'hF0B8;

endpackage

// File: rtl/hdlc_crc16.sv
// hdlc_crc16
//   Byte-wide CRC-16/X.25 accumulator (reflected, LSB of data first).
//   Ports:
//     clk   in   clock, rising edge
//     reset in   synchronous active-high reset, presets crc to CRC_INIT
//     init  in   re-preset crc to CRC_INIT (has priority over en)
//     en    in   fold data into crc this cycle
//     data  in   [7:0] byte to fold in
//     crc   out  [15:0] current CRC register
module hdlc_crc16
  import hdlc_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        init,
  input  logic        en,
  input  logic [7:0]  data,
  output logic [15:0] crc
);

  logic [15:0] crc_nxt;

  always_comb begin
    crc_nxt = crc;
    for (int i = 0; i < 8; i++) begin
      if (crc_nxt[0] ^ data[i]) crc_nxt = (crc_nxt >> 1) ^ CRC_POLY;
      else                      crc_nxt = crc_nxt >> 1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset)     crc <= CRC_INIT;
    else if (init) crc <= CRC_INIT;
    else if (en)   crc <= crc_nxt;
  end

endmodule

// File: rtl/hdlc_deframer.sv
// hdlc_deframer
//   Recovers HDLC payload bytes from a destuffed serial bit stream. An
//   upstream stage flags, one cycle late, which bit was a stuffed zero,
//   closed a flag, or belonged to a run of seven or more ones.
//
//   Optional feature: define HDLC_DEFRAMER_FCS_EN to check the CRC-16/X.25
//   FCS; otherwise fcs_ok simply follows frame_done.
//
//   Parameters:
//     MAX_BYTES   maximum bytes per frame, FCS bytes included
//   Ports:
//     clk         in   clock, rising edge
//     reset       in   synchronous active-high reset
//     in          in   raw serial line bit
//     disc        in   previous bit was a stuffed zero
//     flag        in   previous bit closed a flag
//     err         in   seven or more consecutive ones seen
//     out_valid   out  one-cycle payload byte strobe
//     out_data    out  [7:0] payload byte, first received bit in bit 0
//     out_sof     out  first byte of a frame (only with out_valid)
//     frame_done  out  frame closed on an octet boundary
//     frame_abort out  frame abandoned (misaligned, line error, too long)
//     fcs_ok      out  FCS good, meaningful only with frame_done
//
//   state | meaning
//   HUNT  | out of sync, line bits ignored until a flag
//   OPEN  | flag seen, no byte of the frame emitted yet
//   DATA  | at least one byte of the frame emitted
module hdlc_deframer
  import hdlc_pkg::*;
#(
  parameter int MAX_BYTES = 64
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       in,
  input  logic       disc,
  input  logic       flag,
  input  logic       err,
  output logic       out_valid,
  output logic [7:0] out_data,
  output logic       out_sof,
  output logic       frame_done,
  output logic       frame_abort,
  output logic       fcs_ok
);

  localparam int BC_W = $clog2(MAX_BYTES + 2);

  state_e state, state_nxt;

  logic             in_d;
  logic [WIN_W-1:0] window;
  logic [CNT_W-1:0] count;
  logic [BC_W-1:0]  byte_cnt;

  logic             accept;
  logic             full;
  logic             over;
  logic             emit;
  logic             open_entry;
  logic             sof_nxt;
  logic             done_nxt;
  logic             abort_nxt;
  logic [WIN_W-1:0] win_acc;

  // state register
  always_ff @(posedge clk) begin
    if (reset) state <= HUNT;
    else       state <= state_nxt;
  end

  // next state; err outranks flag, flag outranks everything else
  always_comb begin
    state_nxt = state;
    case (state)
      HUNT: begin
        if (!err && flag) state_nxt = OPEN;
      end
      OPEN: begin
        if (err)       state_nxt = HUNT;
        else if (flag) state_nxt = OPEN;
        else if (over) state_nxt = HUNT;
        else if (emit) state_nxt = DATA;
      end
      DATA: begin
        if (err)       state_nxt = HUNT;
        else if (flag) state_nxt = OPEN;
        else if (over) state_nxt = HUNT;
      end
      default: state_nxt = HUNT;
    endcase
  end

  // output / datapath decode
  always_comb begin
    accept     = (state != HUNT) && !err && !flag && !disc;
    win_acc    = window | (WIN_W'(in_d) << count);
    // the accept that fills the window releases its oldest byte; the
    // newest RSV_BITS bits stay behind in case they are a closing flag
    full       = accept && (count == CNT_W'(WIN_W - 1));
    over       = full && (byte_cnt == BC_W'(MAX_BYTES));
    emit       = full && !over;
    open_entry = !err && flag;
    sof_nxt    = emit && (state == OPEN);
    done_nxt   = (state == DATA) && !err && flag && (count == CNT_W'(RSV_BITS));
    abort_nxt  = ((state == DATA) && (err || (flag && (count != CNT_W'(RSV_BITS)))))
                 || over;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      in_d        <= 1'b0;
      window      <= '0;
      count       <= '0;
      byte_cnt    <= '0;
      out_valid   <= 1'b0;
      out_data    <= '0;
      out_sof     <= 1'b0;
      frame_done  <= 1'b0;
      frame_abort <= 1'b0;
    end else begin
      in_d        <= in;
      out_valid   <= emit;
      out_sof     <= sof_nxt;
      frame_done  <= done_nxt;
      frame_abort <= abort_nxt;
      if (emit) out_data <= win_acc[7:0];

      if (open_entry || (state_nxt == HUNT)) begin
        window <= '0;
        count  <= '0;
      end else if (full) begin
        window <= {8'b0, win_acc[WIN_W-1:8]};
        count  <= CNT_W'(RSV_BITS);
      end else if (accept) begin
        window <= win_acc;
        count  <= count + 1'b1;
      end

      if (open_entry) byte_cnt <= '0;
      else if (emit)  byte_cnt <= byte_cnt + 1'b1;
    end
  end

`ifdef HDLC_DEFRAMER_FCS_EN
  logic [15:0] crc;
  logic        fcs_ok_q;

  hdlc_crc16 u_crc (
    .clk   (clk),
    .reset (reset),
    .init  (open_entry),
    .en    (emit),
    .data  (win_acc[7:0]),
    .crc   (crc)
  );

  // the last byte is folded in at least one cycle before the closing
  // flag is recognised, so crc already holds the full residue here
  always_ff @(posedge clk) begin
    if (reset) fcs_ok_q <= 1'b0;
    else       fcs_ok_q <= done_nxt && (crc == CRC_RESIDUE)
                           && (byte_cnt >= BC_W'(3));
  end

  assign fcs_ok = fcs_ok_q;
`else
  assign fcs_ok = frame_done;
`endif

endmodule

// File: tb/tb_hdlc_deframer.sv
module tb_hdlc_deframer;
  import hdlc_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       in;
  logic       disc;
  logic       flag;
  logic       err;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_sof;
  logic       frame_done;
  logic       frame_abort;
  logic       fcs_ok;

  always #5 clk = ~clk;

  hdlc_deframer #(.MAX_BYTES(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .in          (in),
    .disc        (disc),
    .flag        (flag),
    .err         (err),
    .out_valid   (out_valid),
    .out_data    (out_data),
    .out_sof     (out_sof),
    .frame_done  (frame_done),
    .frame_abort (frame_abort),
    .fcs_ok      (fcs_ok)
  );

  int n_checks = 0;
  int n_fail   = 0;

  int         n_valid, n_sof, n_done, n_abort, n_fcs;
  logic [7:0] rx_bytes [8];
  logic       first_sof;

  int   rx_ones, tx_ones;
  logic pend_d, pend_f, pend_e;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 'h%0h, expected 'h%0h", tag, obs, exp);
    end
  endtask

  task automatic clr_mon();
    n_valid = 0; n_sof = 0; n_done = 0; n_abort = 0; n_fcs = 0;
    first_sof = 1'b0;
    for (int i = 0; i < 8; i++) rx_bytes[i] = 8'h00;
  endtask

  task automatic tick_sample();
    @(posedge clk);
    #1;
    if (out_valid) begin
      if (n_valid < 8) rx_bytes[n_valid] = out_data;
      if (n_valid == 0) first_sof = out_sof;
      n_valid++;
    end
    if (out_sof)     n_sof++;
    if (frame_done)  n_done++;
    if (frame_abort) n_abort++;
    if (fcs_ok)      n_fcs++;
  endtask

  // line bit plus the upstream destuffer's verdict on the previous bit
  task automatic line_bit(input logic b);
    in   = b;
    disc = pend_d;
    flag = pend_f;
    err  = pend_e;
    pend_d = 1'b0; pend_f = 1'b0; pend_e = 1'b0;
    if (b) begin
      rx_ones++;
      if (rx_ones >= 7) pend_e = 1'b1;
    end else begin
      if (rx_ones == 6)      pend_f = 1'b1;
      else if (rx_ones == 5) pend_d = 1'b1;
      rx_ones = 0;
    end
    tick_sample();
  endtask

  task automatic send_data_bit(input logic b);
    line_bit(b);
    if (b) begin
      tx_ones++;
      if (tx_ones == 5) begin
        line_bit(1'b0);
        tx_ones = 0;
      end
    end else begin
      tx_ones = 0;
    end
  endtask

  task automatic send_byte(input logic [7:0] v);
    for (int i = 0; i < 8; i++) send_data_bit(v[i]);
  endtask

  task automatic send_flag();
    logic [7:0] f;
    f = 8'h7E;
    tx_ones = 0;
    for (int i = 0; i < 8; i++) line_bit(f[i]);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) line_bit(1'b0);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, " out_valid"},   32'(out_valid),   32'd0);
    check({tag, " out_data"},    32'(out_data),    32'd0);
    check({tag, " out_sof"},     32'(out_sof),     32'd0);
    check({tag, " frame_done"},  32'(frame_done),  32'd0);
    check({tag, " frame_abort"}, 32'(frame_abort), 32'd0);
    check({tag, " fcs_ok"},      32'(fcs_ok),      32'd0);
    check({tag, " state"},       32'(dut.state),   32'(HUNT));
  endtask

  function automatic logic [15:0] crc_x25(input logic [7:0] b0, input logic [7:0] b1);
    logic [15:0] c;
    logic [7:0]  d [2];
    c = 16'hFFFF;
    d[0] = b0;
    d[1] = b1;
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < 8; i++) begin
        if (c[0] ^ d[k][i]) c = (c >> 1) ^ 16'h8408;
        else                c = c >> 1;
      end
    return c;
  endfunction

  initial begin
    logic [15:0] fcs;

    reset = 1'b1; in = 1'b0; disc = 1'b0; flag = 1'b0; err = 1'b0;
    pend_d = 1'b0; pend_f = 1'b0; pend_e = 1'b0;
    rx_ones = 0; tx_ones = 0;
    clr_mon();
    repeat (2) @(posedge clk);
    #1;
    check_outputs_zero("reset");
    reset = 1'b0;

    // single byte 0xA5, aligned close
    idle(2);
    clr_mon();
    send_flag();
    send_byte(8'hA5);
    send_flag();
    idle(2);
    check("a5 n_valid",  32'(n_valid),     32'd1);
    check("a5 data",     32'(rx_bytes[0]), 32'hA5);
    check("a5 sof",      32'(first_sof),   32'd1);
    check("a5 n_done",   32'(n_done),      32'd1);
    check("a5 n_abort",  32'(n_abort),     32'd0);
`ifdef HDLC_DEFRAMER_FCS_EN
    check("a5 n_fcs",    32'(n_fcs),       32'd0);
`else
    check("a5 n_fcs",    32'(n_fcs),       32'd1);
`endif

    // 0x3F: stuffed zero after five ones must be dropped
    clr_mon();
    send_flag();
    send_byte(8'h3F);
    send_flag();
    idle(2);
    check("3f n_valid",  32'(n_valid),     32'd1);
    check("3f data",     32'(rx_bytes[0]), 32'h3F);
    check("3f n_done",   32'(n_done),      32'd1);
    check("3f n_abort",  32'(n_abort),     32'd0);

    // 12 payload bits: one byte out, then misaligned close
    clr_mon();
    send_flag();
    send_byte(8'h5A);
    send_data_bit(1'b1);
    send_data_bit(1'b0);
    send_data_bit(1'b0);
    send_data_bit(1'b1);
    send_flag();
    idle(2);
    check("odd n_valid", 32'(n_valid),     32'd1);
    check("odd data",    32'(rx_bytes[0]), 32'h5A);
    check("odd n_abort", 32'(n_abort),     32'd1);
    check("odd n_done",  32'(n_done),      32'd0);

    // two bytes out, then seven ones
    clr_mon();
    send_flag();
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h33);
    for (int i = 0; i < 7; i++) line_bit(1'b1);
    line_bit(1'b0);
    check("err n_valid", 32'(n_valid),     32'd2);
    check("err byte0",   32'(rx_bytes[0]), 32'h11);
    check("err byte1",   32'(rx_bytes[1]), 32'h22);
    check("err n_sof",   32'(n_sof),       32'd1);
    check("err n_abort", 32'(n_abort),     32'd1);
    check("err n_done",  32'(n_done),      32'd0);
    check("err state",   32'(dut.state),   32'(HUNT));
    clr_mon();
    for (int i = 0; i < 6; i++) line_bit(1'b1);
    line_bit(1'b0);
    idle(2);
    check("hunt flag strobes", 32'(n_valid + n_done + n_abort), 32'd0);
    check("hunt flag state",   32'(dut.state), 32'(OPEN));

    // MAX_BYTES=4: fifth byte turns into an abort
    clr_mon();
    send_flag();
    for (int i = 1; i <= 6; i++) send_byte(8'(i));
    idle(2);
    check("max n_valid", 32'(n_valid),     32'd4);
    check("max byte3",   32'(rx_bytes[3]), 32'h04);
    check("max n_sof",   32'(n_sof),       32'd1);
    check("max n_abort", 32'(n_abort),     32'd1);
    check("max n_done",  32'(n_done),      32'd0);
    check("max state",   32'(dut.state),   32'(HUNT));

`ifdef HDLC_DEFRAMER_FCS_EN
    // good FCS, then one FCS bit flipped
    fcs = ~crc_x25(8'h01, 8'h02);
    clr_mon();
    send_flag();
    send_byte(8'h01);
    send_byte(8'h02);
    send_byte(fcs[7:0]);
    send_byte(fcs[15:8]);
    send_flag();
    idle(2);
    check("fcs n_valid", 32'(n_valid), 32'd4);
    check("fcs n_done",  32'(n_done),  32'd1);
    check("fcs ok",      32'(n_fcs),   32'd1);
    check("fcs n_abort", 32'(n_abort), 32'd0);
    clr_mon();
    send_flag();
    send_byte(8'h01);
    send_byte(8'h02);
    send_byte(fcs[7:0] ^ 8'h01);
    send_byte(fcs[15:8]);
    send_flag();
    idle(2);
    check("badfcs n_done", 32'(n_done), 32'd1);
    check("badfcs ok",     32'(n_fcs),  32'd0);
`else
    fcs = 16'h0000;
`endif

    // reset after three bytes: silent discard, reset beats err/flag
    clr_mon();
    send_flag();
    send_byte(8'h21);
    send_byte(8'h42);
    send_byte(8'h63);
    send_byte(8'h14);
    check("rst n_valid", 32'(n_valid), 32'd3);
    reset = 1'b1; in = 1'b1; disc = 1'b0; flag = 1'b1; err = 1'b1;
    @(posedge clk);
    #1;
    check_outputs_zero("midreset");
    reset = 1'b0;
    pend_d = 1'b0; pend_f = 1'b0; pend_e = 1'b0;
    rx_ones = 0; tx_ones = 0;
    clr_mon();
    idle(3);
    check("rst n_abort", 32'(n_abort), 32'd0);
    check("rst n_valid post", 32'(n_valid), 32'd0);

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule
